// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_pkg
// Purpose  : Shared NES controller definitions: button bit positions used by
//            every paddle consumer, and the pad-reader poll state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package nes_pkg;

  // Bit positions inside the active-high buttons byte (4021 shift-out order)
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Poll sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SAMPLE = 3'd2,
    PULSE  = 3'd3,
    DONE   = 3'd4
  } nes_state_e;

endpackage
`default_nettype wire

// File: rtl/nes_pad_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_reader_if
// Purpose  : Bundle of frame strobe, controller wires and button snapshot.
//            master = the pad reader, slave = controller/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface nes_pad_reader_if;
  logic       vSyncStart;
  logic       nesData;
  logic       nesLatch;
  logic       nesClock;
  logic [7:0] buttons;
  logic       buttonsValid;
  logic       busy;

  modport master (
    input  vSyncStart, nesData,
    output nesLatch, nesClock, buttons, buttonsValid, busy
  );

  modport slave (
    output vSyncStart, nesData,
    input  nesLatch, nesClock, buttons, buttonsValid, busy
  );
endinterface
`default_nettype wire

// File: rtl/nes_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : nes_tick_gen
// Purpose  : Enable-gated modulo-TICK_DIV counter that flags the last cycle of
//            each protocol tick; synchronous clear restarts the tick.
// Revision : 1.0 - initial release
// ============================================================================
module nes_tick_gen #(
  parameter int TICK_DIV = 150
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic clr,
  output logic      tickEnd
);

  logic [9:0] cnt_q;
  logic [9:0] cnt_d;

  // Terminal count of the current tick
  always_comb tickEnd = (cnt_q == 10'(TICK_DIV - 1));

  // Next count: clear wins, otherwise advance while enabled and wrap at terminal
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 10'd0;
    end else if (en) begin
      cnt_d = tickEnd ? 10'd0 : cnt_q + 10'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 10'd0;
    else     cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_reader
// Purpose  : Once-per-frame serial poll of a 4021-based NES controller; the
//            eight button bits are published as one atomic active-high byte.
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_reader
  import nes_pkg::*;
#(
  parameter int TICK_DIV    = 150,
  parameter int LATCH_TICKS = 2
) (
  input wire logic         pixelClock,
  input wire logic         reset,
  nes_pad_reader_if.master bus
);

  nes_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] buttons_q, buttons_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       busy_q, busy_d;
  logic       latch_q, latch_d;
  logic       nclk_q, nclk_d;
  logic       valid_q, valid_d;
  logic       tick_clr;
  logic       tick_en;
  logic       tick_end;

  // Tick runs only in the timed states; restarted on each poll start
  always_comb tick_en = (state_q == LATCH) || (state_q == SAMPLE) || (state_q == PULSE);

  nes_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (pixelClock),
    .rst     (reset),
    .en      (tick_en),
    .clr     (tick_clr),
    .tickEnd (tick_end)
  );

  // Poll sequencing; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lcnt_d    = lcnt_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    tick_clr  = 1'b0;
    sync1_d   = bus.nesData;
    sync2_d   = sync1_q;

    case (state_q)
      IDLE: begin
        if (bus.vSyncStart) begin
          state_d  = LATCH;
          tick_clr = 1'b1;
          idx_d    = 3'd0;
          lcnt_d   = 3'd0;
          shift_d  = 8'h00;
        end
      end
      LATCH: begin
        if (tick_end) begin
          if (lcnt_q == 3'(LATCH_TICKS - 1)) begin
            state_d = SAMPLE;
            idx_d   = 3'd0;
          end else begin
            lcnt_d = lcnt_q + 3'd1;
          end
        end
      end
      SAMPLE: begin
        // Sample at tick end: the data line has settled through the synchronizer
        if (tick_end) begin
          shift_d[idx_q] = ~sync2_q;
          state_d        = PULSE;
        end
      end
      PULSE: begin
        if (tick_end) begin
          if (idx_q == 3'(BTN_RIGHT)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SAMPLE;
          end
        end
      end
      DONE: begin
        buttons_d = shift_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    latch_d = (state_d == LATCH);
    nclk_d  = (state_d != PULSE);
    valid_d = (state_q == DONE);
  end

  // State and output registers
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      lcnt_q    <= 3'd0;
      shift_q   <= 8'h00;
      buttons_q <= 8'h00;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lcnt_q    <= lcnt_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      busy_q    <= busy_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.buttons      = buttons_q;
  assign bus.buttonsValid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.nesLatch     = latch_q;
  assign bus.nesClock     = nclk_q;

endmodule
`default_nettype wire

// File: doc/nes_pad_reader.md
# nes_pad_reader

Serial reader for one NES controller (4021 shift register), sitting directly upstream of the player paddle logic. Once per frame, triggered by the VGA vertical-sync-start strobe, it latches the controller, clocks out the 8 button bits, and presents them as an active-high `buttons` byte. The byte is updated atomically, and well before the next `vSyncStart`, so paddles always consume a stable snapshot.

## Interface
Parameters:
- `TICK_DIV`, 150: pixelClock cycles per protocol tick (6 µs at 25 MHz); legal range 4..1023.
- `LATCH_TICKS`, 2: latch pulse width in ticks (12 µs); legal range 1..7.

Ports:
- `pixelClock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high; sampled on `pixelClock` rising edge.
- `vSyncStart`  in  1  one-cycle frame strobe from the VGA timing block; starts a poll.
- `nesData`  in  1  controller serial data, active-low, asynchronous.
- `nesLatch`  out  1  controller latch, active-high.
- `nesClock`  out  1  controller clock, idle high.
- `buttons`  out  8  active-high buttons: bit 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `buttonsValid`  out  1  one-cycle pulse when `buttons` updates.
- `busy`  out  1  high while a poll is in progress.

## Operation
- `nesData` passes through a 2-flop synchronizer before use.
- A tick counter runs 0..TICK_DIV-1 only while busy. `tickEnd` is asserted when the count equals TICK_DIV-1.
- FSM states:
  - IDLE: `nesLatch`=0, `nesClock`=1. On `vSyncStart`, go to LATCH; clear the tick counter, bit index and tick-in-state count.
  - LATCH: `nesLatch`=1, `nesClock`=1. Lasts LATCH_TICKS ticks, then goes to SAMPLE with bit index 0.
  - SAMPLE: `nesLatch`=0, `nesClock`=1. Lasts 1 tick. On the tickEnd cycle, `shift[idx] <= ~syncData`. Then goes to PULSE.
  - PULSE: `nesClock`=0. Lasts 1 tick. At tickEnd, if idx==7 go to DONE; otherwise idx+1 and go to SAMPLE. The rising `nesClock` edge shifts the next bit.
  - DONE: 1 cycle. `buttons <= shift`, `buttonsValid`=1, then go to IDLE.
- `vSyncStart` in any state other than IDLE is ignored; the poll is not restarted.
- With no controller, `nesData` is pulled high and `buttons` reads 8'h00.
- `reset` at any time: FSM goes to IDLE and counters clear. `buttons`=8'h00, `nesLatch`=0, `nesClock`=1, `buttonsValid`=0, `busy`=0. Any partial shift data is discarded and `buttons` is not touched mid-poll.

## Timing
- Reset values: `buttons`=0, `buttonsValid`=0, `busy`=0, `nesLatch`=0, `nesClock`=1.
- All outputs are registered.
- `busy` and `nesLatch` rise on the cycle after the `vSyncStart` cycle.
- Poll length is (LATCH_TICKS + 16)·TICK_DIV cycles in LATCH/SAMPLE/PULSE, plus 1 DONE cycle. `busy` falls with DONE.
- With defaults, the poll takes 2700+1 cycles ≈ 108 µs, well inside the vertical blank.
- Sampling happens at the end of the 6 µs SAMPLE tick, ≥2 cycles after the last `nesClock` edge, so synchronizer latency (2 cycles) is absorbed.
- `buttons` changes only on the cycle `buttonsValid` is high; it holds between polls.
- Counter widths: tick counter 10 bits, bit index 3 bits, latch tick count 3 bits. All compares are equality; there is no wrap past terminal values.

## Structure
- Shared package `nes_pkg`:
  - button index constants `BTN_A`..`BTN_RIGHT` (0..7), used by every paddle consumer;
  - FSM state enum `{IDLE, LATCH, SAMPLE, PULSE, DONE}`.
- Optional sub-module `nes_tick_gen`: enable-gated modulo-TICK_DIV counter with a `tickEnd` output and synchronous clear. The synchronizer stays inline.

## Test plan
Benches run TICK_DIV=4, LATCH_TICKS=2 with a behavioural 4021 model: a parallel load while latch is high, shifting on the `nesClock` rise, active-low data.
- Reset, then idle 50 cycles -> `buttons`=8'h00, `nesLatch`=0, `nesClock`=1, `busy`=0.
- Model presses Up+A (raw 8'b1110_1110), pulse `vSyncStart` -> `nesLatch` high for 8 cycles, then 8 low pulses of 4 cycles. `buttonsValid` pulses at cycle 74 after the strobe, with `buttons`=8'h11.
- Second `vSyncStart` at cycle 20 of a poll -> ignored; exactly one `buttonsValid`, total busy 73 cycles.
- Unplugged (`nesData` held 1), poll -> `buttons`=8'h00 and `buttonsValid` pulses.
- Poll with Down pressed, asserting `reset` at cycle 40 -> `busy`=0, `nesClock`=1, `buttons` stays at its prior value of 0. A following poll yields 8'h20.
- Back-to-back polls with buttons changing between them -> each `buttons` reflects only its own latch moment; no mixed bits.
